poly_voice_adsr: RTL and testbench
==================================

Name: poly_voice_adsr

Overview:
- Parametrised polyphonic voice allocator with a per-voice ADSR envelope engine.
- Takes decoded key events (note number plus press/release) from the PS/2 keyboard front end.
- Assigns each event to one of VOICES voices and runs an independent attack/decay/sustain/release state machine per voice.
- Its per-voice note numbers and envelope levels drive the downstream frequency lookup and voice mixer.

Parameters:
- VOICES, 8, number of voices (2..16).
- NOTE_W, 6, note number width.
- LEVEL_W, 16, envelope level width, unsigned; full scale = 2^LEVEL_W-1.
- TICK_DIV, 480, clocks per envelope update tick (>=1).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- key_valid, in, 1, one-cycle strobe: key event present.
- key_press, in, 1, 1 = note-on, 0 = note-off; qualified by key_valid.
- key_note, in, NOTE_W, note number of the event.
- attack_step, in, LEVEL_W, level increment per tick in ATTACK.
- decay_step, in, LEVEL_W, level decrement per tick in DECAY.
- sustain_level, in, LEVEL_W, DECAY target level.
- release_step, in, LEVEL_W, level decrement per tick in RELEASE.
- voice_note, out, VOICES*NOTE_W, packed note per voice; voice i at [i*NOTE_W +: NOTE_W].
- voice_level, out, VOICES*LEVEL_W, packed envelope level per voice.
- voice_active, out, VOICES, bit i set when voice i is not IDLE.
- voice_stolen, out, 1, one-cycle pulse when a note-on steals a non-IDLE voice.

Behaviour:
- Reset (async assert, sync release):
  - All voices IDLE, level 0, note 0.
  - voice_active 0, voice_stolen 0.
  - Tick counter 0, round-robin pointer 0.
- Tick:
  - Free-running counter 0..TICK_DIV-1.
  - tick = 1 on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Per-voice FSM, evaluated only on tick cycles:
  - IDLE: hold, level 0.
  - ATTACK: level += attack_step, saturating at full scale; on reaching full scale -> DECAY in the same update.
  - DECAY: level -= decay_step, clamped at sustain_level; on reaching it -> SUSTAIN. If level is already <= sustain_level on entry, load sustain_level and go to SUSTAIN.
  - SUSTAIN: hold level, including a level of 0. The voice stays active until note-off.
  - RELEASE: level -= release_step, clamped at 0; on reaching 0 -> IDLE.
  - A step of 0 holds the voice in its current state indefinitely. This is legal.
- Note-on (key_valid & key_press), applied at the next clock edge; outputs reflect it one cycle after the strobe:
  - Retrigger: if any non-IDLE voice holds key_note, the lowest-index such voice -> ATTACK, keeping its current level (no click).
  - Else free voice: the lowest-index IDLE voice gets note = key_note, level 0, ATTACK.
  - Else steal: the RELEASE voice with the lowest level (ties -> lowest index). If no voice is in RELEASE, the voice at the round-robin pointer, and the pointer increments modulo VOICES. The stolen voice gets note = key_note, level 0, ATTACK, and voice_stolen pulses.
- Note-off (key_valid & !key_press):
  - Every voice in ATTACK, DECAY or SUSTAIN holding key_note -> RELEASE; its level is unchanged that cycle.
  - A note-off with no match is ignored.
- Simultaneous key event and tick:
  - The key event wins for the targeted voice(s); they skip that tick's envelope update.
  - All other voices update normally.
- Back-to-back key events on consecutive cycles are all accepted. Allocation uses state already updated by the previous event.
- Arithmetic: compute in LEVEL_W+1 bits, then clamp; no wrap-around ever.
- Parameter or step changes mid-envelope take effect on the next tick.
- Reset mid-note returns everything to reset values immediately.

Test Plan:
- Reset, then note-on 12 with attack_step=16384, decay_step=4096, sustain_level=32768, TICK_DIV=4 -> voice 0 active, note 12. Level reads 16384, 32768, 49152, 65535 over ticks (DECAY), then 61439 … reaching 32768 and holding in SUSTAIN.
- From SUSTAIN: note-off 12 with release_step=8192 -> level 24576, 16384, 8192, 0. Voice 0 goes IDLE and voice_active[0] drops on the tick where level reaches 0.
- VOICES=8: note-on 0..7 fills voices 0..7. Note-on 8 -> voice 0 stolen, voice_stolen=1 for one cycle. Note-on 9 -> voice 1 stolen.
- Voices 2 and 5 in RELEASE with levels 300 and 100, all others SUSTAIN, note-on 20 -> voice 5 takes note 20 at level 0; round-robin pointer unchanged.
- Note-on 7 while voice 3 holds note 7 at level 40000 in DECAY -> voice 3 re-enters ATTACK from 40000; no other voice changes.
- Note-on coinciding with a tick cycle, plus reset_n asserted mid-ATTACK -> targeted voice skips that tick's update. After reset all outputs are 0 asynchronously.

Source files
------------

// File: rtl/poly_voice_adsr.sv
// Polyphonic voice allocator: routes key events to VOICES voices and runs an
// independent ADSR envelope per voice, updated once per TICK_DIV clocks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | voice free, level forced to 0
//   S_ATTACK  | level rises by attack_step per tick up to full scale
//   S_DECAY   | level falls by decay_step per tick down to sustain_level
//   S_SUSTAIN | level held until note-off
//   S_RELEASE | level falls by release_step per tick down to 0, then IDLE
module poly_voice_adsr #(
    parameter int VOICES   = 8,
    parameter int NOTE_W   = 6,
    parameter int LEVEL_W  = 16,
    parameter int TICK_DIV = 480
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        key_valid,
    input  logic                        key_press,
    input  logic [NOTE_W-1:0]           key_note,
    input  logic [LEVEL_W-1:0]          attack_step,
    input  logic [LEVEL_W-1:0]          decay_step,
    input  logic [LEVEL_W-1:0]          sustain_level,
    input  logic [LEVEL_W-1:0]          release_step,
    output logic [VOICES*NOTE_W-1:0]    voice_note,
    output logic [VOICES*LEVEL_W-1:0]   voice_level,
    output logic [VOICES-1:0]           voice_active,
    output logic                        voice_stolen
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [LEVEL_W-1:0] FULL = {LEVEL_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              r_state     [VOICES];
    logic [LEVEL_W-1:0]  r_level     [VOICES];
    logic [NOTE_W-1:0]   r_note      [VOICES];
    state_t              w_state_nxt [VOICES];
    logic [LEVEL_W-1:0]  w_level_nxt [VOICES];
    logic [NOTE_W-1:0]   w_note_nxt  [VOICES];

    logic [CNT_W-1:0]    r_tick_cnt;
    logic                w_tick;
    logic [IDX_W-1:0]    r_rr;
    logic [IDX_W-1:0]    w_rr_nxt;
    logic                r_stolen;

    logic                w_on;
    logic                w_off;
    logic                w_hit;
    logic                w_free;
    logic                w_rel;
    logic                w_steal;
    logic                w_rr_adv;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [IDX_W-1:0]    w_free_idx;
    logic [IDX_W-1:0]    w_rel_idx;
    logic [IDX_W-1:0]    w_tgt;
    logic [LEVEL_W-1:0]  w_rel_lvl;

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
        end
    end

    assign w_on  = key_valid & key_press;
    assign w_off = key_valid & ~key_press;

    // Candidate searches; each scan keeps the lowest index that qualifies.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_rel      = 1'b0;
        w_rel_idx  = '0;
        w_rel_lvl  = FULL;
        for (int i = 0; i < VOICES; i++) begin
            if (!w_hit && r_state[i] != S_IDLE && r_note[i] == key_note) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!w_free && r_state[i] == S_IDLE) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == S_RELEASE && (!w_rel || r_level[i] < w_rel_lvl)) begin
                w_rel     = 1'b1;
                w_rel_idx = IDX_W'(i);
                w_rel_lvl = r_level[i];
            end
        end
    end

    always_comb begin
        w_tgt = r_rr;
        if (w_hit) begin
            w_tgt = w_hit_idx;
        end else if (w_free) begin
            w_tgt = w_free_idx;
        end else if (w_rel) begin
            w_tgt = w_rel_idx;
        end
    end

    assign w_steal  = w_on & ~w_hit & ~w_free;
    assign w_rr_adv = w_steal & ~w_rel;
    assign w_rr_nxt = (r_rr == IDX_W'(VOICES - 1)) ? '0 : r_rr + IDX_W'(1);

    // Key events override the envelope for the voices they touch, so a
    // targeted voice simply misses a coincident tick.
    always_comb begin : p_next
        logic [LEVEL_W:0] w_sum;
        logic [LEVEL_W:0] w_dif_d;
        logic [LEVEL_W:0] w_dif_r;
        w_sum   = '0;
        w_dif_d = '0;
        w_dif_r = '0;
        for (int i = 0; i < VOICES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_level_nxt[i] = r_level[i];
            w_note_nxt[i]  = r_note[i];
            w_sum   = {1'b0, r_level[i]} + {1'b0, attack_step};
            w_dif_d = {1'b0, r_level[i]} - {1'b0, decay_step};
            w_dif_r = {1'b0, r_level[i]} - {1'b0, release_step};
            if (w_on && w_tgt == IDX_W'(i)) begin
                w_state_nxt[i] = S_ATTACK;
                if (!w_hit) begin
                    w_note_nxt[i]  = key_note;
                    w_level_nxt[i] = '0;
                end
            end else if (w_off && r_note[i] == key_note &&
                         (r_state[i] == S_ATTACK || r_state[i] == S_DECAY ||
                          r_state[i] == S_SUSTAIN)) begin
                w_state_nxt[i] = S_RELEASE;
            end else if (w_tick) begin
                case (r_state[i])
                    S_IDLE: begin
                        w_level_nxt[i] = '0;
                    end
                    S_ATTACK: begin
                        if (attack_step != '0) begin
                            if (w_sum >= {1'b0, FULL}) begin
                                w_level_nxt[i] = FULL;
                                w_state_nxt[i] = S_DECAY;
                            end else begin
                                w_level_nxt[i] = w_sum[LEVEL_W-1:0];
                            end
                        end
                    end
                    S_DECAY: begin
                        if (r_level[i] <= sustain_level) begin
                            w_level_nxt[i] = sustain_level;
                            w_state_nxt[i] = S_SUSTAIN;
                        end else if (decay_step != '0) begin
                            if (w_dif_d[LEVEL_W] || w_dif_d[LEVEL_W-1:0] <= sustain_level) begin
                                w_level_nxt[i] = sustain_level;
                                w_state_nxt[i] = S_SUSTAIN;
                            end else begin
                                w_level_nxt[i] = w_dif_d[LEVEL_W-1:0];
                            end
                        end
                    end
                    S_SUSTAIN: begin
                        w_level_nxt[i] = r_level[i];
                    end
                    S_RELEASE: begin
                        if (release_step != '0) begin
                            if (w_dif_r[LEVEL_W] || w_dif_r[LEVEL_W-1:0] == '0) begin
                                w_level_nxt[i] = '0;
                                w_state_nxt[i] = S_IDLE;
                            end else begin
                                w_level_nxt[i] = w_dif_r[LEVEL_W-1:0];
                            end
                        end
                    end
                    default: begin
                        w_level_nxt[i] = '0;
                        w_state_nxt[i] = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                r_state[i] <= S_IDLE;
                r_level[i] <= '0;
                r_note[i]  <= '0;
            end
            r_rr     <= '0;
            r_stolen <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_level[i] <= w_level_nxt[i];
                r_note[i]  <= w_note_nxt[i];
            end
            r_stolen <= w_steal;
            if (w_rr_adv) begin
                r_rr <= w_rr_nxt;
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_out
        assign voice_note[g*NOTE_W +: NOTE_W]    = r_note[g];
        assign voice_level[g*LEVEL_W +: LEVEL_W] = r_level[g];
        assign voice_active[g]                   = (r_state[g] != S_IDLE);
    end

    assign voice_stolen = r_stolen;

endmodule

// File: tb/tb_poly_voice_adsr.sv
// Directed bench for poly_voice_adsr: allocation table plus envelope,
// retrigger, steal-priority, tick-collision and async reset sequences.
module tb_poly_voice_adsr;

    localparam int V  = 8;
    localparam int NW = 6;
    localparam int LW = 16;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            key_valid = 1'b0;
    logic            key_press = 1'b0;
    logic [NW-1:0]   key_note = '0;
    logic [LW-1:0]   attack_step = '0;
    logic [LW-1:0]   decay_step = '0;
    logic [LW-1:0]   sustain_level = '0;
    logic [LW-1:0]   release_step = '0;
    logic [V*NW-1:0] voice_note;
    logic [V*LW-1:0] voice_level;
    logic [V-1:0]    voice_active;
    logic            voice_stolen;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_cnt;

    poly_voice_adsr #(.VOICES(V), .NOTE_W(NW), .LEVEL_W(LW), .TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n),
        .key_valid(key_valid), .key_press(key_press), .key_note(key_note),
        .attack_step(attack_step), .decay_step(decay_step),
        .sustain_level(sustain_level), .release_step(release_step),
        .voice_note(voice_note), .voice_level(voice_level),
        .voice_active(voice_active), .voice_stolen(voice_stolen)
    );

    always #5 clk = ~clk;

    // Reference tick phase: tick edge follows a cycle where tb_cnt == TD-1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 0;
        else          tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
    end

    function automatic int lvl(input int v);
        return int'(voice_level[v*LW +: LW]);
    endfunction

    function automatic int nte(input int v);
        return int'(voice_note[v*NW +: NW]);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        key_valid = 1'b0;
        attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic key_evt(input logic press, input int note);
        @(negedge clk);
        while (tb_cnt == TD - 1) @(negedge clk);
        key_valid = 1'b1; key_press = press; key_note = NW'(note);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic key_on_tick(input int note);
        @(negedge clk);
        while (tb_cnt != TD - 1) @(negedge clk);
        key_valid = 1'b1; key_press = 1'b1; key_note = NW'(note);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic tick_wait();
        @(negedge clk);
        while (tb_cnt != TD - 1) @(negedge clk);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic press;
        int   note;
        int   voice;
        int   exp_note;
        int   exp_stolen;
        int   exp_active;
    } vec_t;

    vec_t vecs [15];

    int decay_exp [8] = '{61439, 57343, 53247, 49151, 45055, 40959, 36863, 32768};
    int rel_exp   [4] = '{24576, 16384, 8192, 0};

    initial begin
        // allocation table: steps 0 keep every envelope frozen at level 0
        for (int k = 0; k < 8; k++) vecs[k] = '{1'b1, k, k, k, 0, (1 << (k + 1)) - 1};
        vecs[8]  = '{1'b1, 8,  0, 8,  1, 255};
        vecs[9]  = '{1'b1, 9,  1, 9,  1, 255};
        vecs[10] = '{1'b0, 8,  0, 8,  0, 255};
        vecs[11] = '{1'b1, 30, 0, 30, 1, 255};
        vecs[12] = '{1'b1, 31, 2, 31, 1, 255};
        vecs[13] = '{1'b1, 31, 2, 31, 0, 255};
        vecs[14] = '{1'b0, 50, 3, 3,  0, 255};

        // ---- reset state + attack/decay/sustain/release ramp ----
        do_reset();
        #1;
        chk("rst_active", int'(voice_active), 0);
        chk("rst_level_any", int'(|voice_level), 0);
        chk("rst_note_any", int'(|voice_note), 0);
        chk("rst_stolen", int'(voice_stolen), 0);

        attack_step = 16384; decay_step = 4096; sustain_level = 32768;
        key_evt(1'b1, 12);
        chk("on12_active", int'(voice_active), 1);
        chk("on12_note", nte(0), 12);
        chk("on12_level", lvl(0), 0);
        for (int k = 1; k <= 4; k++) begin
            tick_wait();
            chk($sformatf("attack_%0d", k), lvl(0), (k == 4) ? 65535 : k * 16384);
        end
        for (int k = 0; k < 8; k++) begin
            tick_wait();
            chk($sformatf("decay_%0d", k), lvl(0), decay_exp[k]);
        end
        tick_wait();
        chk("sustain_hold", lvl(0), 32768);
        chk("sustain_active", int'(voice_active), 1);
        release_step = 8192;
        key_evt(1'b0, 12);
        chk("off12_level", lvl(0), 32768);
        for (int k = 0; k < 4; k++) begin
            tick_wait();
            chk($sformatf("release_%0d", k), lvl(0), rel_exp[k]);
            chk($sformatf("release_active_%0d", k), int'(voice_active[0]), (k == 3) ? 0 : 1);
        end

        // ---- table-driven allocation / steal / retrigger ----
        do_reset();
        for (int k = 0; k < 15; k++) begin
            key_evt(vecs[k].press, vecs[k].note);
            chk($sformatf("tbl%0d_note", k), nte(vecs[k].voice), vecs[k].exp_note);
            chk($sformatf("tbl%0d_stolen", k), int'(voice_stolen), vecs[k].exp_stolen);
            chk($sformatf("tbl%0d_active", k), int'(voice_active), vecs[k].exp_active);
            chk($sformatf("tbl%0d_level", k), lvl(vecs[k].voice), 0);
        end

        // ---- steal prefers lowest-level RELEASE voice, pointer untouched ----
        do_reset();
        for (int k = 0; k < 8; k++) key_evt(1'b1, 10 + k);
        attack_step = 65535;
        tick_wait();
        attack_step = 0; decay_step = 65535; sustain_level = 300;
        tick_wait();
        chk("sus300_v4", lvl(4), 300);
        decay_step = 0; release_step = 200;
        key_evt(1'b0, 15);
        tick_wait();
        release_step = 0;
        key_evt(1'b0, 12);
        chk("rel_v5", lvl(5), 100);
        chk("rel_v2", lvl(2), 300);
        key_evt(1'b1, 20);
        chk("steal_rel_note", nte(5), 20);
        chk("steal_rel_level", lvl(5), 0);
        chk("steal_rel_pulse", int'(voice_stolen), 1);
        chk("steal_rel_v2_untouched", nte(2), 12);
        key_evt(1'b1, 21);
        chk("steal_rel2_note", nte(2), 21);
        key_evt(1'b1, 22);
        chk("steal_rr0_note", nte(0), 22);
        chk("steal_rr0_v1", nte(1), 11);

        // ---- retrigger from DECAY keeps level; back-to-back events ----
        do_reset();
        for (int k = 4; k < 8; k++) key_evt(1'b1, k);
        attack_step = 65535;
        tick_wait();
        attack_step = 0; decay_step = 25535; sustain_level = 0;
        tick_wait();
        decay_step = 0;
        chk("decay_40000", lvl(3), 40000);
        key_evt(1'b1, 7);
        chk("retrig_level", lvl(3), 40000);
        chk("retrig_note", nte(3), 7);
        chk("retrig_stolen", int'(voice_stolen), 0);
        chk("retrig_active", int'(voice_active), 15);
        chk("retrig_v2_level", lvl(2), 40000);
        attack_step = 1000;
        tick_wait();
        chk("retrig_attack", lvl(3), 41000);
        chk("retrig_v2_hold", lvl(2), 40000);
        attack_step = 0;
        @(negedge clk);
        key_valid = 1'b1; key_press = 1'b1; key_note = 6'd50;
        @(negedge clk);
        key_note = 6'd51;
        @(negedge clk);
        key_valid = 1'b0;
        chk("b2b_v4", nte(4), 50);
        chk("b2b_v5", nte(5), 51);
        chk("b2b_active", int'(voice_active), 63);

        // ---- key event coinciding with a tick, then async reset ----
        do_reset();
        attack_step = 1000;
        key_evt(1'b1, 40);
        tick_wait();
        chk("coll_pre_v0", lvl(0), 1000);
        key_evt(1'b1, 41);
        key_on_tick(40);
        chk("coll_v0_skip", lvl(0), 1000);
        chk("coll_v1_upd", lvl(1), 1000);
        tick_wait();
        chk("coll_v0_next", lvl(0), 2000);
        chk("coll_v1_next", lvl(1), 2000);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_active", int'(voice_active), 0);
        chk("async_rst_level", int'(|voice_level), 0);
        chk("async_rst_note", int'(|voice_note), 0);
        chk("async_rst_stolen", int'(voice_stolen), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
